quire_posit_encoder: RTL

- Read-out end of the posit MAC quire: takes one finished sign-magnitude quire from the accumulator and encodes it as a WIDTH-bit posit with es=EXP.
- Multi-cycle unit: segmented leading-one scan, then normalize, round and pack.
- Sits between the accumulator's final-result registers and the output/writeback path.
- Handshake: valid/ready on input and output.

---
 rtl/quire_posit_encoder.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/quire_posit_encoder.sv
// Quire-to-posit read-out: segmented leading-one scan, normalize, round, pack.
// Optional round-to-nearest-even build via macro QUIRE_ENC_RNE_EN (default: truncate).
module quire_posit_encoder #(
   parameter int WIDTH    = 8,
   parameter int K        = 9,
   parameter int EXP      = 2,
   parameter int ACC      = (2**EXP)*(WIDTH-2),
   parameter int ACC_HEAD = $clog2(K)+2
) (
   input  logic                clk_i,
   input  logic                rstn,
   input  logic                q_vld,
   output logic                q_rdy,
   input  logic                acc_sign,
   input  logic [ACC_HEAD-1:0] acc_100,
   input  logic [ACC-1:0]      acc_000,
   input  logic [ACC-1:0]      acc_001,
   input  logic [ACC-1:0]      acc_010,
   input  logic [ACC-1:0]      acc_011,
   output logic [WIDTH-1:0]    posit_o,
   output logic                posit_vld,
   input  logic                posit_rdy,
   output logic                sat_o
);

   localparam int QW  = ACC_HEAD + 4*ACC;
   localparam int PW  = $clog2(QW);
   localparam int LW  = $clog2(ACC);
   localparam int FW  = WIDTH + EXP;
   localparam int SW  = 2*FW;
   localparam int SCW = PW + 2;
   localparam logic signed [SCW-1:0] LIM_S = SCW'((WIDTH-2)*(2**EXP));
   localparam logic [WIDTH-1:0] MAXPOS = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MINPOS = WIDTH'(1);

   typedef enum logic [2:0] {IDLE, SCAN, NORM, ENC, DONE} state_t;

   function automatic logic [LW-1:0] lead_pos(input logic [ACC-1:0] v);
      lead_pos = '0;
      for (int b = 0; b < ACC; b++)
         if (v[b]) lead_pos = LW'(b);
   endfunction

   function automatic logic round_inc(input logic guard, input logic sticky, input logic lsb);
`ifdef QUIRE_ENC_RNE_EN
      round_inc = guard & (sticky | lsb);
`else
      round_inc = 1'b0;
`endif
   endfunction

   state_t                  state_q, state_d;
   logic                    q_rdy_q, q_rdy_d;
   logic                    sign_q, sign_d;
   logic [QW-1:0]           mag_q, mag_d;
   logic [2:0]              seg_q, seg_d;
   logic [PW-1:0]           p_q, p_d;
   logic                    zero_q, zero_d;
   logic [FW-1:0]           frac_q, frac_d;
   logic                    sticky_q, sticky_d;
   logic signed [SCW-1:0]   scale_q, scale_d;
   logic [WIDTH-1:0]        posit_q, posit_d;
   logic                    sat_q, sat_d;

   logic [ACC-1:0]          seg_val;
   logic [QW-1:0]           aligned;
   logic signed [SCW-1:0]   kv;
   int                      ki, rlen;
   logic [SW-1:0]           regm, tail, stream;
   logic [WIDTH-2:0]        body;
   logic                    guard, sticky;
   logic [WIDTH-1:0]        rounded, mag_out;

   always_ff @(posedge clk_i) begin
      if (!rstn) begin
         state_q  <= IDLE;
         q_rdy_q  <= 1'b0;
         sign_q   <= 1'b0;
         mag_q    <= '0;
         seg_q    <= '0;
         p_q      <= '0;
         zero_q   <= 1'b0;
         frac_q   <= '0;
         sticky_q <= 1'b0;
         scale_q  <= '0;
         posit_q  <= '0;
         sat_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         q_rdy_q  <= q_rdy_d;
         sign_q   <= sign_d;
         mag_q    <= mag_d;
         seg_q    <= seg_d;
         p_q      <= p_d;
         zero_q   <= zero_d;
         frac_q   <= frac_d;
         sticky_q <= sticky_d;
         scale_q  <= scale_d;
         posit_q  <= posit_d;
         sat_q    <= sat_d;
      end
   end

   // Datapath helpers; the segment under scan is always moved down to bit 0.
   always_comb begin
      seg_val = ACC'(mag_q >> ((4 - int'(seg_q)) * ACC));
      aligned = mag_q << (QW - int'(p_q));
      kv      = scale_q >>> EXP;
      ki      = int'(kv);
      if (ki >= 0) begin
         regm = ~({SW{1'b1}} >> (ki + 1));
         rlen = ki + 2;
      end else begin
         regm = {1'b1, {(SW-1){1'b0}}} >> (-ki);
         rlen = 1 - ki;
      end
      tail    = {scale_q[EXP-1:0], frac_q, {(SW-EXP-FW){1'b0}}};
      stream  = regm | (tail >> rlen);
      body    = stream[SW-1 -: WIDTH-1];
      guard   = stream[SW-WIDTH];
      sticky  = (|stream[SW-WIDTH-1:0]) | sticky_q;
      rounded = {1'b0, body} + WIDTH'(round_inc(guard, sticky, body[0]));
   end

   always_comb begin
      state_d  = state_q;
      sign_d   = sign_q;
      mag_d    = mag_q;
      seg_d    = seg_q;
      p_d      = p_q;
      zero_d   = zero_q;
      frac_d   = frac_q;
      sticky_d = sticky_q;
      scale_d  = scale_q;
      posit_d  = posit_q;
      sat_d    = sat_q;
      mag_out  = '0;
      case (state_q)
         IDLE: begin
            if (q_vld && q_rdy_q) begin
               mag_d   = {acc_100, acc_000, acc_001, acc_010, acc_011};
               sign_d  = acc_sign;
               seg_d   = '0;
               zero_d  = 1'b0;
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (|seg_val) begin
               p_d     = PW'((4 - int'(seg_q)) * ACC + int'(lead_pos(seg_val)));
               state_d = NORM;
            end else if (seg_q == 3'd4) begin
               zero_d  = 1'b1;
               p_d     = '0;
               state_d = NORM;
            end else begin
               seg_d = seg_q + 3'd1;
            end
         end
         NORM: begin
            // Shifting by QW-p drops the hidden one off the top.
            frac_d   = aligned[QW-1 -: FW];
            sticky_d = |aligned[QW-1-FW:0];
            scale_d  = $signed({2'b00, p_q}) - $signed(SCW'(2*ACC));
            state_d  = ENC;
         end
         ENC: begin
            if (zero_q) begin
               mag_out = '0;
               sat_d   = 1'b0;
            end else if (scale_q >= LIM_S || rounded[WIDTH-1]) begin
               mag_out = MAXPOS;
               sat_d   = 1'b1;
            end else if (scale_q < -LIM_S || rounded == '0) begin
               mag_out = MINPOS;
               sat_d   = 1'b1;
            end else begin
               mag_out = rounded;
               sat_d   = 1'b0;
            end
            posit_d = (sign_q && !zero_q) ? (~mag_out + WIDTH'(1)) : mag_out;
            state_d = DONE;
         end
         DONE: begin
            if (posit_rdy) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      q_rdy_d = (state_d == IDLE);
   end

   assign q_rdy     = q_rdy_q;
   assign posit_vld = (state_q == DONE);
   assign posit_o   = posit_q;
   assign sat_o     = sat_q;

endmodule
